// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin transaction arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN,
        ARB_RELEASE
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request after last_id,
// wrapping modulo NUM_REQ.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   off;
    int                   pos;

    // Rotate via a doubled vector so the scan starts just past last_id.
    always_comb begin
        dbl     = {req, req};
        rot     = NUM_REQ'(dbl >> (int'(last_id) + 1));
        any_req = |req;
        off     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end
        pos = int'(last_id) + 1 + off;
        if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
        end
        winner = ID_W'(pos);
    end

endmodule

// File: rtl/rr_txn_arbiter.sv
// Round-robin arbiter granting one shared transaction resource at a time,
// with done/drop release, hold-time limit and a bus turnaround cycle.
module rr_txn_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 16,
    localparam int ID_W     = id_width(NUM_REQ),
    localparam int HC_W     = id_width(MAX_HOLD)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               timeout
);

    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0] ID_LAST   = ID_W'(NUM_REQ - 1);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [HC_W-1:0]    hold_cnt;
    logic [HC_W-1:0]    hold_d;
    logic [ID_W-1:0]    last_id;
    logic [ID_W-1:0]    last_d;
    logic [ID_W-1:0]    id_d;
    logic [ID_W-1:0]    winner;
    logic [NUM_REQ-1:0] gnt_d;
    logic               busy_d;
    logic               timeout_d;
    logic               any_req;
    logic               rel_done;
    logic               rel_drop;
    logic               rel_max;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req    (req),
        .last_id(last_id),
        .winner (winner),
        .any_req(any_req)
    );

    assign rel_done = done[gnt_id];
    assign rel_drop = ~req[gnt_id];
    assign rel_max  = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt;
        id_d      = gnt_id;
        busy_d    = busy;
        timeout_d = 1'b0;
        hold_d    = hold_cnt;
        last_d    = last_id;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    gnt_d   = NUM_REQ'(1) << winner;
                    id_d    = winner;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    state_d = ARB_OWN;
                end
            end
            ARB_OWN: begin
                if (rel_done || rel_drop || rel_max) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    last_d    = gnt_id;
                    hold_d    = '0;
                    // Hold expiry flags timeout only when nothing else released.
                    timeout_d = rel_max && !rel_done && !rel_drop;
                    state_d   = ARB_RELEASE;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last_id  <= ID_LAST;
        end else begin
            state_q  <= state_d;
            gnt      <= gnt_d;
            gnt_id   <= id_d;
            busy     <= busy_d;
            timeout  <= timeout_d;
            hold_cnt <= hold_d;
            last_id  <= last_d;
        end
    end

    a_gnt_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt)
    );

    a_timeout_src: assert property (
        @(posedge clk) disable iff (!rst_n)
        timeout |-> ($past(state_q) == ARB_OWN)
    );

endmodule
